// File: rtl/bus_arbiter_2x1.sv
// Two-master, one-slave bus arbiter with round-robin tie-break and a
// per-tenure timeout. Master 0 is instruction fetch, master 1 is data.
// Ownership ends when the owner drops cyc; a stalled slave is reclaimed
// after TIMEOUT_CYCLES cycles without s_ack and the owner gets one err pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | bus free, arbitrating between pending requests
// ST_OWN0  | master 0 owns the slave, request fields passed through
// ST_OWN1  | master 1 owns the slave, request fields passed through
// ST_ABORT | timed-out tenure, one-cycle err pulse to the aborted owner
module bus_arbiter_2x1 #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk_core,
    input  logic                  rst_core,

    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    input  logic                  m0_we,
    input  logic [3:0]            m0_sel,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_data_i,
    output logic [31:0]           m0_data_o,
    output logic                  m0_ack,
    output logic                  m0_err,

    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    input  logic                  m1_we,
    input  logic [3:0]            m1_sel,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_data_i,
    output logic [31:0]           m1_data_o,
    output logic                  m1_ack,
    output logic                  m1_err,

    output logic                  s_cyc,
    output logic                  s_stb,
    output logic                  s_we,
    output logic [3:0]            s_sel,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [31:0]           s_data_o,
    input  logic [31:0]           s_data_i,
    input  logic                  s_ack,

    output logic [1:0]            grant
);

    // Counter is at least 8 bits; widened only for very long timeouts.
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic TO_ENABLED = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic [CNT_W-1:0] to_cnt;
    logic             owner_cyc;
    logic             owning;
    logic             timeout_hit;
    logic             pick_m1;

    // Ownership qualifiers shared by next-state and counter logic.
    always_comb begin
        owning    = (state == ST_OWN0) || (state == ST_OWN1);
        owner_cyc = 1'b0;
        if (state == ST_OWN0) owner_cyc = m0_cyc;
        if (state == ST_OWN1) owner_cyc = m1_cyc;
        timeout_hit = TO_ENABLED && (to_cnt == TO_LAST) && !s_ack;
        // m1 wins when alone, or on a tie when m0 held the bus last.
        pick_m1 = m1_cyc && (!m0_cyc || (last_grant == 1'b0));
    end

    // State register.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state: arbitrate in IDLE, hold while owner cyc is high, reclaim on timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (m0_cyc || m1_cyc) state_nxt = pick_m1 ? ST_OWN1 : ST_OWN0;
            end
            ST_OWN0, ST_OWN1: begin
                if (!owner_cyc)       state_nxt = ST_IDLE;
                else if (timeout_hit) state_nxt = ST_ABORT;
            end
            ST_ABORT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Round-robin memory: records the winner of every grant out of IDLE.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core)
            last_grant <= 1'b1;
        else if ((state == ST_IDLE) && (m0_cyc || m1_cyc))
            last_grant <= pick_m1;
    end

    // Saturating count of owned cycles since the last slave ack.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core)
            to_cnt <= '0;
        else if (owning && owner_cyc && !s_ack) begin
            if (to_cnt != {CNT_W{1'b1}}) to_cnt <= to_cnt + 1'b1;
        end else
            to_cnt <= '0;
    end

    // Outputs: pass owner's request through, route response back, gate the rest.
    always_comb begin
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_we      = 1'b0;
        s_sel     = '0;
        s_addr    = '0;
        s_data_o  = '0;
        m0_ack    = 1'b0;
        m0_err    = 1'b0;
        m0_data_o = '0;
        m1_ack    = 1'b0;
        m1_err    = 1'b0;
        m1_data_o = '0;
        grant     = 2'b00;
        case (state)
            ST_OWN0: begin
                s_cyc     = m0_cyc;
                s_stb     = m0_stb;
                s_we      = m0_we;
                s_sel     = m0_sel;
                s_addr    = m0_addr;
                s_data_o  = m0_data_i;
                m0_ack    = s_ack;
                m0_data_o = s_data_i;
                grant     = 2'b01;
            end
            ST_OWN1: begin
                s_cyc     = m1_cyc;
                s_stb     = m1_stb;
                s_we      = m1_we;
                s_sel     = m1_sel;
                s_addr    = m1_addr;
                s_data_o  = m1_data_i;
                m1_ack    = s_ack;
                m1_data_o = s_data_i;
                grant     = 2'b10;
            end
            ST_ABORT: begin
                // last_grant still names the owner whose tenure was cut short.
                m0_err = (last_grant == 1'b0);
                m1_err = (last_grant == 1'b1);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter_2x1.sv
module tb_bus_arbiter_2x1;

    localparam int TO = 4;
    localparam logic [31:0] A0 = 32'h0000_00AA;
    localparam logic [31:0] A1 = 32'h0000_0100;
    localparam logic [31:0] SD = 32'hDEAD_BEEF;

    logic        clk_core = 1'b0;
    logic        rst_core;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_addr, m1_addr, m0_data_i, m1_data_i;
    logic [31:0] m0_data_o, m1_data_o;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [3:0]  s_sel;
    logic [31:0] s_addr, s_data_o, s_data_i;
    logic [1:0]  grant;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_core = ~clk_core;

    bus_arbiter_2x1 #(.TIMEOUT_CYCLES(TO), .ADDR_WIDTH(32)) dut (
        .clk_core(clk_core), .rst_core(rst_core),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
        .m0_addr(m0_addr), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
        .m1_addr(m1_addr), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
        .s_addr(s_addr), .s_data_o(s_data_o), .s_data_i(s_data_i),
        .s_ack(s_ack), .grant(grant)
    );

    typedef struct {
        logic        c0, c1, ack;
        logic [1:0]  g;
        logic        scyc;
        logic [31:0] addr;
        logic        a0, a1, e0, e1;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    endtask

    task automatic add(input logic c0, input logic c1, input logic ack, input logic [1:0] g,
                       input logic scyc, input logic [31:0] addr,
                       input logic a0, input logic a1, input logic e0, input logic e1);
        vec_t v;
        v.c0 = c0; v.c1 = c1; v.ack = ack; v.g = g; v.scyc = scyc; v.addr = addr;
        v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1;
        tbl.push_back(v);
    endtask

    task automatic drive_fixed(input logic c0, input logic c1, input logic ack);
        m0_cyc = c0; m0_stb = c0; m1_cyc = c1; m1_stb = c1; s_ack = ack;
    endtask

    // Reference model: who owns the bus, who waits, and for how long without ack.
    int m_owner, m_last, m_cnt, m_aborted;
    bit m_abort;

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_cnt = 0; m_aborted = -1; m_abort = 0;
    endtask

    task automatic model_step();
        logic oc;
        if (m_abort) begin
            m_abort = 0;
        end else if (m_owner < 0) begin
            if (m0_cyc || m1_cyc) begin
                if (m0_cyc && m1_cyc) m_owner = 1 - m_last;
                else                  m_owner = m0_cyc ? 0 : 1;
                m_last = m_owner;
                m_cnt  = 0;
            end
        end else begin
            oc = (m_owner == 0) ? m0_cyc : m1_cyc;
            if (!oc) m_owner = -1;
            else if (!s_ack && (m_cnt == TO - 1)) begin
                m_abort = 1; m_aborted = m_owner; m_owner = -1;
            end else m_cnt = s_ack ? 0 : m_cnt + 1;
        end
    endtask

    task automatic model_check();
        logic [1:0]  eg;
        logic [70:0] es, as;
        logic [33:0] e0, e1;
        eg = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        es = '0;
        if (m_owner == 0) es = {m0_cyc, m0_stb, m0_we, m0_sel, m0_addr, m0_data_i};
        if (m_owner == 1) es = {m1_cyc, m1_stb, m1_we, m1_sel, m1_addr, m1_data_i};
        e0 = (m_owner == 0) ? {s_ack, 1'b0, s_data_i} : {1'b0, (m_abort && m_aborted == 0), 32'h0};
        e1 = (m_owner == 1) ? {s_ack, 1'b0, s_data_i} : {1'b0, (m_abort && m_aborted == 1), 32'h0};
        as = {s_cyc, s_stb, s_we, s_sel, s_addr, s_data_o};
        chk("rnd_grant", grant, eg);
        chk("rnd_slave_bus", as, es);
        chk("rnd_m0_resp", {m0_ack, m0_err, m0_data_o}, e0);
        chk("rnd_m1_resp", {m1_ack, m1_err, m1_data_o}, e1);
    endtask

    initial begin
        logic hold0, hold1;
        rst_core = 1'b1;
        m0_we = 1'b0; m0_sel = 4'h3; m0_addr = A0; m0_data_i = 32'h1111_0000;
        m1_we = 1'b1; m1_sel = 4'hC; m1_addr = A1; m1_data_i = 32'h2222_0001;
        s_data_i = SD;
        drive_fixed(1'b1, 1'b1, 1'b1);

        // m1 alone, slave acks on second owned cycle
        add(0,1,0, 2'b00,0,0,  0,0,0,0);
        add(0,1,0, 2'b10,1,A1, 0,0,0,0);
        add(0,1,1, 2'b10,1,A1, 0,1,0,0);
        add(0,0,0, 2'b10,0,A1, 0,0,0,0);
        add(0,0,0, 2'b00,0,0,  0,0,0,0);
        // simultaneous requests, two rounds of alternation with one IDLE gap
        add(1,1,0, 2'b00,0,0,  0,0,0,0);
        add(1,1,1, 2'b01,1,A0, 1,0,0,0);
        add(1,1,0, 2'b01,1,A0, 0,0,0,0);
        add(0,1,0, 2'b01,0,A0, 0,0,0,0);
        add(0,1,0, 2'b00,0,0,  0,0,0,0);
        add(1,1,1, 2'b10,1,A1, 0,1,0,0);
        add(1,1,0, 2'b10,1,A1, 0,0,0,0);
        add(1,0,0, 2'b10,0,A1, 0,0,0,0);
        add(1,1,0, 2'b00,0,0,  0,0,0,0);
        add(1,1,0, 2'b01,1,A0, 0,0,0,0);
        add(0,1,0, 2'b01,0,A0, 0,0,0,0);
        add(0,1,0, 2'b00,0,0,  0,0,0,0);
        add(0,1,0, 2'b10,1,A1, 0,0,0,0);
        add(0,0,0, 2'b10,0,A1, 0,0,0,0);
        add(0,0,1, 2'b00,0,0,  0,0,0,0);
        // m0 timeout with a silent slave, stray ack in ABORT is dropped
        add(1,0,0, 2'b00,0,0,  0,0,0,0);
        add(1,0,0, 2'b01,1,A0, 0,0,0,0);
        add(1,0,0, 2'b01,1,A0, 0,0,0,0);
        add(1,0,0, 2'b01,1,A0, 0,0,0,0);
        add(1,0,0, 2'b01,1,A0, 0,0,0,0);
        add(1,0,1, 2'b00,0,0,  0,0,1,0);
        add(0,0,0, 2'b00,0,0,  0,0,0,0);
        // m1: an ack restarts the timeout window
        add(0,1,0, 2'b00,0,0,  0,0,0,0);
        add(0,1,0, 2'b10,1,A1, 0,0,0,0);
        add(0,1,0, 2'b10,1,A1, 0,0,0,0);
        add(0,1,1, 2'b10,1,A1, 0,1,0,0);
        add(0,1,0, 2'b10,1,A1, 0,0,0,0);
        add(0,1,0, 2'b10,1,A1, 0,0,0,0);
        add(0,1,0, 2'b10,1,A1, 0,0,0,0);
        add(0,1,0, 2'b10,1,A1, 0,0,0,0);
        add(0,0,0, 2'b00,0,0,  0,0,0,1);
        add(0,0,0, 2'b00,0,0,  0,0,0,0);

        repeat (2) @(posedge clk_core);
        @(negedge clk_core);
        chk("reset_grant", grant, 2'b00);
        chk("reset_slave", {s_cyc, s_stb, s_we, s_sel, s_addr, s_data_o}, 71'h0);
        chk("reset_resp", {m0_ack, m0_err, m0_data_o, m1_ack, m1_err, m1_data_o}, 68'h0);
        rst_core = 1'b0;

        foreach (tbl[i]) begin
            drive_fixed(tbl[i].c0, tbl[i].c1, tbl[i].ack);
            #1;
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
            chk($sformatf("tbl%0d_s_cyc", i), {s_cyc, s_stb}, {tbl[i].scyc, tbl[i].scyc});
            chk($sformatf("tbl%0d_s_addr", i), s_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_m0", i), {m0_ack, m0_err, m0_data_o},
                {tbl[i].a0, tbl[i].e0, (tbl[i].g == 2'b01) ? SD : 32'h0});
            chk($sformatf("tbl%0d_m1", i), {m1_ack, m1_err, m1_data_o},
                {tbl[i].a1, tbl[i].e1, (tbl[i].g == 2'b10) ? SD : 32'h0});
            @(negedge clk_core);
        end

        // m1 waits behind a long m0 tenure, then is granted after one IDLE cycle
        drive_fixed(1'b1, 1'b0, 1'b0);
        @(negedge clk_core);
        drive_fixed(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("hold_grant", grant, 2'b01);
            chk("hold_m1_ack", m1_ack, 1'b0);
            chk("hold_m0_ack", m0_ack, 1'b1);
            @(negedge clk_core);
        end
        drive_fixed(1'b0, 1'b1, 1'b0);
        #1 chk("drop_grant", {grant, s_cyc}, {2'b01, 1'b0});
        @(negedge clk_core);
        #1 chk("gap_grant", grant, 2'b00);
        @(negedge clk_core);
        #1 chk("handover_grant", {grant, s_cyc, m1_ack}, {2'b10, 1'b1, 1'b0});
        @(negedge clk_core);
        drive_fixed(1'b0, 1'b0, 1'b0);
        @(negedge clk_core);
        @(negedge clk_core);

        // asynchronous reset mid-tenure of m1
        drive_fixed(1'b0, 1'b1, 1'b0);
        @(negedge clk_core);
        s_ack = 1'b1;
        #1 chk("pre_rst_own1", {grant, s_cyc, s_stb, m1_ack}, {2'b10, 1'b1, 1'b1, 1'b1});
        #2 rst_core = 1'b1;
        #1 chk("async_rst_drop", {grant, s_cyc, s_stb, m1_ack, m1_err}, 6'h0);
        @(negedge clk_core);
        rst_core = 1'b0;
        drive_fixed(1'b1, 1'b1, 1'b0);
        #1 chk("post_rst_idle", grant, 2'b00);
        @(negedge clk_core);
        #1 chk("post_rst_m0_wins", grant, 2'b01);
        drive_fixed(1'b0, 1'b0, 1'b0);

        // randomized traffic against the reference model
        @(negedge clk_core);
        rst_core = 1'b1;
        @(negedge clk_core);
        rst_core = 1'b0;
        model_reset();
        hold0 = 1'b0; hold1 = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (hold0) hold0 = ($urandom_range(5) != 0);
            else       hold0 = ($urandom_range(2) == 0);
            if (hold1) hold1 = ($urandom_range(5) != 0);
            else       hold1 = ($urandom_range(2) == 0);
            m0_cyc = hold0; m1_cyc = hold1;
            m0_stb = 1'($urandom); m1_stb = 1'($urandom);
            m0_we  = 1'($urandom); m1_we  = 1'($urandom);
            m0_sel = 4'($urandom); m1_sel = 4'($urandom);
            m0_addr = $urandom; m1_addr = $urandom;
            m0_data_i = $urandom; m1_data_i = $urandom;
            s_data_i = $urandom;
            s_ack = ($urandom_range(2) == 0);
            #1;
            model_check();
            @(posedge clk_core);
            model_step();
            @(negedge clk_core);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
